// File: rtl/frame_bank_mgr.sv
// frame_bank_mgr: N-bank frame buffer rotation between camera writer and DDR reader
module frame_bank_mgr #(
  parameter int BANK_NUM  = 4,
  parameter int BANK_W    = 2,
  parameter int REPEAT_EN = 1,
  parameter int CNT_W     = 16
) (
  input  logic              phy_clk,
  input  logic              sys_rst,
  input  logic              frame_wr_done,
  input  logic              frame_rd_done,
  output logic [BANK_W-1:0] wr_bank,
  output logic              wr_load,
  output logic [BANK_W-1:0] rd_bank,
  output logic              rd_load,
  output logic              rd_repeat,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  repeat_cnt
);
  typedef enum logic {W_LOAD, W_BUSY} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_BUSY, R_WAIT} r_state_t;
  localparam logic [BANK_W:0] NB = (BANK_W+1)'(BANK_NUM);
  if (BANK_NUM < 3 || BANK_NUM > 16) begin : g_bad_num
    $error("frame_bank_mgr: BANK_NUM must be within 3..16");
  end
  if (BANK_W != $clog2(BANK_NUM)) begin : g_bad_w
    $error("frame_bank_mgr: BANK_W must equal clog2(BANK_NUM)");
  end
  w_state_t          w_st, w_nxt;
  r_state_t          r_st, r_nxt;
  logic [BANK_W-1:0] latest_bank, rd_bank_nxt, next_wr;
  logic [BANK_W:0]   cand;
  logic              latest_valid, fresh, found, wr_take, rd_take;
  // next-state decode; the reader's upcoming bank is exposed so the writer never steps onto it
  always_comb begin
    wr_take     = w_st == W_BUSY && frame_wr_done;
    rd_take     = r_st == R_LOAD;
    wr_load     = w_st == W_LOAD && !sys_rst;
    rd_bank_nxt = rd_take ? latest_bank : rd_bank;
    w_nxt       = wr_take ? W_LOAD : W_BUSY;
    r_nxt = r_st == R_IDLE ? (latest_valid ? R_LOAD : R_IDLE)
          : r_st == R_LOAD ? R_BUSY
          : r_st == R_BUSY ? (!frame_rd_done ? R_BUSY : (fresh || REPEAT_EN != 0) ? R_LOAD : R_WAIT)
          : (fresh ? R_LOAD : R_WAIT);
  end
  // modulo-BANK_NUM forward scan for the first bank that is not the reader's next bank
  always_comb begin
    next_wr = wr_bank;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k < BANK_NUM; k++) begin
      cand = {1'b0, wr_bank} + (BANK_W+1)'(k);
      cand = cand >= NB ? cand - NB : cand;
      if (!found && cand[BANK_W-1:0] != rd_bank_nxt) begin
        next_wr = cand[BANK_W-1:0];
        found   = 1'b1;
      end
    end
  end
  // writer state, bank rotation and overwrite accounting
  always_ff @(posedge phy_clk) begin
    if (sys_rst) begin
      w_st         <= W_LOAD;
      wr_bank      <= '0;
      latest_bank  <= '0;
      latest_valid <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      w_st <= w_nxt;
      if (wr_take) begin
        wr_bank      <= next_wr;
        latest_bank  <= wr_bank;
        latest_valid <= 1'b1;
        if (fresh && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end
  // a frame completing in the reader's load cycle keeps fresh set
  always_ff @(posedge phy_clk) begin
    fresh <= sys_rst ? 1'b0 : wr_take ? 1'b1 : rd_take ? 1'b0 : fresh;
  end
  // reader state, registered bank load and repeat accounting
  always_ff @(posedge phy_clk) begin
    if (sys_rst) begin
      r_st       <= R_IDLE;
      rd_bank    <= BANK_W'(BANK_NUM - 1);
      rd_load    <= 1'b0;
      rd_repeat  <= 1'b0;
      repeat_cnt <= '0;
    end else begin
      r_st    <= r_nxt;
      rd_load <= rd_take;
      if (rd_take) begin
        rd_bank   <= latest_bank;
        rd_repeat <= !fresh;
        if (!fresh && repeat_cnt != '1) repeat_cnt <= repeat_cnt + CNT_W'(1);
      end
    end
  end
  a_no_collide: assert property (@(posedge phy_clk) disable iff (sys_rst)
    r_st != R_IDLE |-> wr_bank != rd_bank);
endmodule
